mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one Avalon-MM agent port (unified RAM/peripheral bus) between the core's instruction-fetch host (read-only) and its data host (read/write).
- Sits between the CPU's instruction_manager/data_manager buses and the single memory agent, so one-port memories can serve both.
- Round-robin, non-preemptive arbitration. A grant is held until the agent completes the transfer (waitrequest low).

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports; byteenable width is DATA_W/8

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- i_address  in  ADDR_W  instruction host address
- i_read  in  1  instruction host read request
- i_readdata  out  DATA_W  read data to instruction host
- i_waitrequest  out  1  stall to instruction host
- d_address  in  ADDR_W  data host address
- d_read  in  1  data host read request
- d_write  in  1  data host write request
- d_byteenable  in  DATA_W/8  data host byte lanes
- d_writedata  in  DATA_W  data host write data
- d_readdata  out  DATA_W  read data to data host
- d_waitrequest  out  1  stall to data host
- m_address  out  ADDR_W  agent address
- m_read  out  1  agent read strobe
- m_write  out  1  agent write strobe
- m_byteenable  out  DATA_W/8  agent byte lanes
- m_writedata  out  DATA_W  agent write data
- m_readdata  in  DATA_W  agent read data, valid when m_waitrequest=0 with m_read=1
- m_waitrequest  in  1  agent stall
- grant  out  2  debug: {data, instr} one-hot current grant, 2'b00 when idle

Behaviour:
- States are IDLE, GRANT_I and GRANT_D. A last_d bit records which host was served most recently (1 = data host).
- Reset (rst=1 at an edge):
  - state <= IDLE, last_d <= 1, so the first contention goes to instruction.
  - Outputs after reset: m_read=m_write=0, i_waitrequest=d_waitrequest=1, grant=00, m_address/m_writedata/m_byteenable=0.
- IDLE:
  - Define ireq=i_read and dreq=d_read|d_write.
  - Only one of ireq/dreq: go to that host's GRANT state.
  - Both: go to GRANT_I if last_d=1, else GRANT_D.
  - Neither: stay in IDLE.
  - Both waitrequests are 1 and no agent strobe is issued. Minimum arbitration latency is 1 cycle.
- GRANT_x, agent outputs: m_* are driven combinationally from host x.
  - m_read = x's read, m_write = x's write. Instruction host: m_write=0, m_byteenable=all ones, m_writedata=0.
- GRANT_x, handshakes:
  - x_waitrequest = m_waitrequest.
  - The other host sees waitrequest=1.
  - x_readdata = m_readdata.
  - The non-granted host's readdata holds 0.
- GRANT_x, completion: when m_waitrequest=0 and x's request is high, the transfer completes. Next state is IDLE and last_d <= (x==D).
  - Back-to-back transfers therefore cost one IDLE bubble. This is intentional; it avoids re-granting on a stale request.
- GRANT_x, request dropped: if x's request goes low before completion (protocol violation), go to IDLE next edge with last_d unchanged and no strobe.
- Simultaneous d_read and d_write is illegal: m_write takes precedence and m_read is forced to 0.
- Starvation bound: a waiting host is granted within one completed transfer of the other host.
- Reset mid-transfer: strobes drop in the cycle after the reset edge, and the agent transfer is abandoned.

Decomposition:
- Types package additions:
  - arb_state_t enum {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D}
  - arb_grant_t packed struct {bit d; bit i;}
- One sub-module, arb_rr_pick: purely combinational two-way round-robin chooser. Inputs ireq, dreq, last_d; outputs pick_i, pick_d.
- The FSM and output muxing stay in mem_port_arbiter.

Test Plan:
- Reset with rst=1 for 2 cycles, all requests low -> grant=00, m_read=m_write=0, both waitrequests=1.
- i_read=1, i_address=0x100, agent waitrequest 0 immediately with readdata 0xDEADBEEF -> cycle 1 grant=01, m_address=0x100, i_readdata=0xDEADBEEF, i_waitrequest=0; cycle 2 IDLE.
- d_write=1, d_address=0x2000, d_writedata=0x12345678, d_byteenable=0x3, agent stalls 3 cycles -> m_write held 4 cycles with stable address/data/byteenable, d_waitrequest=1 for 4 cycles then 0, i_waitrequest=1 throughout.
- i_read and d_read held high together from reset, zero-wait agent -> grants alternate I, idle, D, idle, I, ...; neither host waits more than 4 cycles.
- Assert rst during GRANT_D with m_waitrequest=1 -> next cycle m_write=0, grant=00; after release, a pending i_read is granted first (last_d=1).
- d_read=1 and d_write=1 together -> m_write=1, m_read=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Grant debug bundle is {data, instr}.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT_I,
    ARB_GRANT_D
  } arb_state_t;

  typedef struct packed {
    bit d;
    bit i;
  } arb_grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Host and agent Avalon-MM signals around the arbiter.
// master: hosts plus agent side, slave: the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_port_arbiter_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_port_arbiter_pkg::DEF_DATA_W
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic [DATA_W-1:0] i_readdata;
  logic              i_waitrequest;

  logic [ADDR_W-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [BE_W-1:0]   d_byteenable;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_waitrequest;

  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic              m_write;
  logic [BE_W-1:0]   m_byteenable;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;
  logic              m_waitrequest;

  modport master (
    output i_address, i_read,
    output d_address, d_read, d_write,
    output d_byteenable, d_writedata,
    output m_readdata, m_waitrequest,
    input  i_readdata, i_waitrequest,
    input  d_readdata, d_waitrequest,
    input  m_address, m_read, m_write,
    input  m_byteenable, m_writedata
  );

  modport slave (
    input  i_address, i_read,
    input  d_address, d_read, d_write,
    input  d_byteenable, d_writedata,
    input  m_readdata, m_waitrequest,
    output i_readdata, i_waitrequest,
    output d_readdata, d_waitrequest,
    output m_address, m_read, m_write,
    output m_byteenable, m_writedata
  );

endinterface

// File: rtl/arb_rr_pick.sv
// Two-way round-robin chooser; last_d=1 favours instr.
// Purely combinational.
module arb_rr_pick (
  input  logic ireq,
  input  logic dreq,
  input  logic last_d,
  output logic pick_i,
  output logic pick_d
);

  assign pick_i = ireq & (~dreq | last_d);
  assign pick_d = dreq & (~ireq | ~last_d);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one Avalon-MM agent between instr and data hosts.
// Non-preemptive round robin with an idle bubble per transfer.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        grant
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t state;
  arb_grant_t grant_q;
  logic       last_d;
  logic       ireq;
  logic       dreq;
  logic       pick_i;
  logic       pick_d;

  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_writedata;
  logic [BE_W-1:0]   m_be;
  logic              m_read;
  logic              m_write;
  logic [DATA_W-1:0] i_rdata;
  logic [DATA_W-1:0] d_rdata;
  logic              i_wait;
  logic              d_wait;

  assign ireq = bus.i_read;
  assign dreq = bus.d_read | bus.d_write;

  arb_rr_pick u_pick (
    .ireq   (ireq),
    .dreq   (dreq),
    .last_d (last_d),
    .pick_i (pick_i),
    .pick_d (pick_d)
  );

  // A dropped request returns to idle without touching last_d.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      last_d  <= 1'b1;
      grant_q <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (pick_i) begin
            state   <= ARB_GRANT_I;
            grant_q <= '{d: 1'b0, i: 1'b1};
          end else if (pick_d) begin
            state   <= ARB_GRANT_D;
            grant_q <= '{d: 1'b1, i: 1'b0};
          end
        end
        ARB_GRANT_I: begin
          if (!ireq || !bus.m_waitrequest) begin
            state   <= ARB_IDLE;
            grant_q <= '0;
            if (ireq) last_d <= 1'b0;
          end
        end
        ARB_GRANT_D: begin
          if (!dreq || !bus.m_waitrequest) begin
            state   <= ARB_IDLE;
            grant_q <= '0;
            if (dreq) last_d <= 1'b1;
          end
        end
        default: begin
          state   <= ARB_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    m_address   = '0;
    m_writedata = '0;
    m_be        = '0;
    m_read      = 1'b0;
    m_write     = 1'b0;
    i_rdata     = '0;
    d_rdata     = '0;
    i_wait      = 1'b1;
    d_wait      = 1'b1;
    unique case (state)
      ARB_GRANT_I: begin
        m_address = bus.i_address;
        m_read    = bus.i_read;
        m_be      = '1;
        i_rdata   = bus.m_readdata;
        i_wait    = bus.m_waitrequest;
      end
      ARB_GRANT_D: begin
        m_address   = bus.d_address;
        m_write     = bus.d_write;
        m_read      = bus.d_read & ~bus.d_write;
        m_be        = bus.d_byteenable;
        m_writedata = bus.d_writedata;
        d_rdata     = bus.m_readdata;
        d_wait      = bus.m_waitrequest;
      end
      default: ;
    endcase
  end

  assign bus.m_address     = m_address;
  assign bus.m_writedata   = m_writedata;
  assign bus.m_byteenable  = m_be;
  assign bus.m_read        = m_read;
  assign bus.m_write       = m_write;
  assign bus.i_readdata    = i_rdata;
  assign bus.d_readdata    = d_rdata;
  assign bus.i_waitrequest = i_wait;
  assign bus.d_waitrequest = d_wait;
  assign grant             = grant_q;

endmodule
